mul_share_arbiter: RTL
======================

# mul_share_arbiter

Sequencer and round-robin arbiter that shares one 16x16 partial-product multiplier cell between two requesters. The cell produces lo*lo, a_lo*b_hi and a_hi*b_lo. The block accepts 32-bit operand pairs over a valid/ready handshake and drives the cell's operand and enable lines. It combines the three partial products into the low 32 bits of the product and returns the result to the granted requester as a one-cycle response pulse. It sits between the two processor-side multiply ports and the shared cell, in the same clock domain.

## Interface
- MUL_LATENCY, 1: cycles from the first cycle of mul_en to valid products at mul_p1..p3. Legal range 1..4.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester N presents an operand pair.
- req0_ready / req1_ready  out  1  operand pair accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  in  32  operands.
- resp0_valid / resp1_valid  out  1  one-cycle result pulse to requester N.
- resp_result  out  32  low 32 bits of a*b; shared by both ports, qualified by respN_valid.
- busy  out  1  high while an operation is in flight (not IDLE).
- mul_src1, mul_src2  out  32  operands to the cell.
- mul_en  out  1  cell register enable.
- mul_p1, mul_p2, mul_p3  in  32  cell products: a_lo*b_lo, a_lo*b_hi, a_hi*b_lo, all unsigned.

## Operation
- States:
  - IDLE: no operation in flight.
  - ISSUE: operands driven to the cell, mul_en high.
  - WAIT: waiting for the cell products.
- Arbitration, in IDLE only:
  - Winner = the requester holding priority if it is valid, else the other requester if it is valid.
  - reqN_ready = (state==IDLE) & (winner==N). Ready may depend on either valid.
  - Valid must not depend on ready.
- Accept (valid & ready):
  - Latch a, b and the owner ID into mul_src1/mul_src2/owner.
  - Priority passes to the non-owner.
  - Go to ISSUE.
- ISSUE / WAIT:
  - mul_src1/mul_src2 are held constant.
  - mul_en is high for exactly MUL_LATENCY cycles, starting in ISSUE.
  - A down-counter (reload MUL_LATENCY-1) steps WAIT; products are sampled in the WAIT cycle after mul_en falls.
- Combine at sample time:
  - result = mul_p1 + ((mul_p2 + mul_p3) << 16), computed modulo 2^32.
  - Bits of p2+p3 above bit 15 and carries beyond bit 31 are discarded.
  - result is registered into resp_result, respOwner_valid is set for the next cycle, and the FSM returns to IDLE.
- The response cycle coincides with IDLE, so a new request can be accepted in the same cycle the previous result is presented.
- Requesters never stall responses; there is no resp_ready.
- Non-winning requests wait with no timeout. Requesters must hold valid and operands stable until ready.
- Reset mid-operation:
  - The in-flight operation is dropped and no response is issued.
  - Priority returns to requester 0.

## Timing
- Reset values:
  - req0_ready = 1 if req0_valid, else 0 (combinational).
  - req1_ready = 1 only if req1_valid and not req0_valid (priority = 0).
  - resp0_valid = resp1_valid = 0, resp_result = 0, busy = 0, mul_en = 0.
  - mul_src1 = mul_src2 = 0, state = IDLE.
- Accept at cycle 0 gives:
  - ISSUE at cycle 1.
  - mul_en high in cycles 1..MUL_LATENCY.
  - Products sampled at the end of cycle MUL_LATENCY+1.
  - respN_valid in cycle MUL_LATENCY+2.
- Latency: accept to response = MUL_LATENCY+2 cycles (3 with the default).
- Throughput: one operation per MUL_LATENCY+2 cycles.
- busy is high from cycle 1 through cycle MUL_LATENCY+1.
- Both valid continuously: grants alternate 0,1,0,1, starting with 0 after reset.
- resp_result holds its value until the next response.

## Test plan
- Single op, default latency:
  - Stimulus: req0 a=0x00030002, b=0x00050004 at cycle 0.
  - Response: req0_ready at cycle 0; mul_en high at cycle 1 only; resp0_valid at cycle 3 with resp_result=0x00160008; resp1_valid stays 0.
- Wrap-around:
  - a=0xFFFFFFFF, b=0xFFFFFFFF -> result 0x00000001.
  - a=0x00010000, b=0x00010000 -> result 0x00000000.
- Contention:
  - Stimulus: both valid from cycle 0, req0 a=2, b=3; req1 a=7, b=6.
  - Response: grant to 0 at cycle 0 with resp0=6 at cycle 3; grant to 1 at cycle 3 with resp1=42 at cycle 6; requester 0 is granted again next.
- Back-to-back on one port:
  - Stimulus: req1 valid continuously with operands 0x10*0x10, then 0x12345*0x10.
  - Response: accepts at cycles 0 and 3; results 0x100 and 0x00123450.
- MUL_LATENCY=3:
  - Stimulus: single op at cycle 0.
  - Response: mul_en high in cycles 1..3; resp at cycle 5; operands stable in cycles 1..4.
- Reset during WAIT:
  - Stimulus: assert reset in cycle 2 of an op.
  - Response: all outputs reach reset values immediately; no respN_valid; first grant after reset goes to req0.

Source files
------------

// File: rtl/mul_share_arbiter_if.sv
// Bundle of requester handshakes, shared response and multiplier-cell lines
// that connects the two multiply ports to mul_share_arbiter.
interface mul_share_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        resp0_valid;
    logic        resp1_valid;
    logic [31:0] resp_result;
    logic        busy;
    logic [31:0] mul_src1;
    logic [31:0] mul_src2;
    logic        mul_en;
    logic [31:0] mul_p1;
    logic [31:0] mul_p2;
    logic [31:0] mul_p3;

    // Arbiter side: consumes requests and cell products
    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  mul_p1, mul_p2, mul_p3,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid, resp_result, busy,
        output mul_src1, mul_src2, mul_en
    );

    // Requester/cell side
    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output mul_p1, mul_p2, mul_p3,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid, resp_result, busy,
        input  mul_src1, mul_src2, mul_en
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one 16x16 partial-product cell between two multiply
// ports; returns the low 32 bits of a*b as a one-cycle response pulse.
module mul_share_arbiter #(
    parameter int MUL_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    mul_share_arbiter_if.slave    bus
);
    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MUL_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state_reg;
    logic              prio_reg;
    logic              owner_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              mul_en_reg;
    logic              busy_reg;
    logic [31:0]       src1_reg;
    logic [31:0]       src2_reg;
    logic [31:0]       result_reg;
    logic [1:0]        resp_valid_reg;

    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [31:0]       req_a [2];
    logic [31:0]       req_b [2];
    logic              accept;
    logic              grant_id;
    logic [31:0]       combined;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign req_a[0]  = bus.req0_a;
    assign req_a[1]  = bus.req1_a;
    assign req_b[0]  = bus.req0_b;
    assign req_b[1]  = bus.req1_b;

    // A port wins when it is valid and either holds priority or the other port is idle
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = (state_reg == IDLE) && req_valid[gi] &&
                                   ((prio_reg == 1'(gi)) || !req_valid[1 - gi]);
        end
    endgenerate

    assign accept   = |req_ready;
    assign grant_id = req_ready[1];

    // Cross terms only contribute their low 16 bits; everything wraps at 2^32
    assign combined = bus.mul_p1 + ((bus.mul_p2 + bus.mul_p3) << 16);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            prio_reg       <= 1'b0;
            owner_reg      <= 1'b0;
            cnt_reg        <= '0;
            mul_en_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            src1_reg       <= '0;
            src2_reg       <= '0;
            result_reg     <= '0;
            resp_valid_reg <= 2'b00;
        end else begin
            resp_valid_reg <= 2'b00;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        src1_reg   <= req_a[grant_id];
                        src2_reg   <= req_b[grant_id];
                        owner_reg  <= grant_id;
                        prio_reg   <= ~grant_id;
                        cnt_reg    <= CNT_RELOAD;
                        mul_en_reg <= 1'b1;
                        busy_reg   <= 1'b1;
                        state_reg  <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    // cnt_reg counts enable cycles still owed after the current one
                    if (mul_en_reg) begin
                        if (cnt_reg == '0) begin
                            mul_en_reg <= 1'b0;
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                        state_reg <= WAIT;
                    end else begin
                        result_reg                <= combined;
                        resp_valid_reg[owner_reg] <= 1'b1;
                        busy_reg                  <= 1'b0;
                        state_reg                 <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready  = req_ready[0];
    assign bus.req1_ready  = req_ready[1];
    assign bus.resp0_valid = resp_valid_reg[0];
    assign bus.resp1_valid = resp_valid_reg[1];
    assign bus.resp_result = result_reg;
    assign bus.busy        = busy_reg;
    assign bus.mul_src1    = src1_reg;
    assign bus.mul_src2    = src2_reg;
    assign bus.mul_en      = mul_en_reg;
endmodule
